// File: rtl/dram_pkg.sv
// Shared encodings and width helpers for the DRAM command timing block.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_e;

    // Encoded id width for an n-entry one-hot select (at least 1 bit).
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_cmd_timing_if.sv
// Command/array bus between dram_ctrl, dram_cmd_timing and dram_bfm.
interface dram_cmd_timing_if #(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned DATA_WIDTH   = 8
);
    import dram_pkg::*;

    localparam int unsigned BW = id_width(NUM_OF_BANKS);
    localparam int unsigned RW = id_width(NUM_OF_ROWS);
    localparam int unsigned CW = id_width(NUM_OF_COLS);

    logic                    cmd_req;
    logic [1:0]              cmd;
    logic [NUM_OF_BANKS-1:0] bank_sel;
    logic [NUM_OF_ROWS-1:0]  row_sel;
    logic [NUM_OF_COLS-1:0]  col_sel;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   dram_din;
    logic                    cmd_ack;
    logic [BW-1:0]           bank_id;
    logic [RW-1:0]           row_id;
    logic [CW-1:0]           col_id;
    logic                    bank_rw;
    logic                    buf_rw;
    logic [DATA_WIDTH-1:0]   dram_dout;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    proto_err;

    modport master (
        output cmd_req, cmd, bank_sel, row_sel, col_sel, wr_data, dram_din,
        input  cmd_ack, bank_id, row_id, col_id, bank_rw, buf_rw,
               dram_dout, rd_data, rd_valid, proto_err
    );

    modport slave (
        input  cmd_req, cmd, bank_sel, row_sel, col_sel, wr_data, dram_din,
        output cmd_ack, bank_id, row_id, col_id, bank_rw, buf_rw,
               dram_dout, rd_data, rd_valid, proto_err
    );

endinterface

// File: rtl/dram_tmr.sv
// Loadable down-counter that stops at zero and flags it.
module dram_tmr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/dram_cmd_timing.sv
// Turns handshaked controller commands into timed DRAM array strobes,
// tracks open rows per bank and flags protocol misuse.
module dram_cmd_timing import dram_pkg::*; #(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned T_RCD        = 3,
    parameter int unsigned T_CL         = 2,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned T_RP         = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    dram_cmd_timing_if.slave io_cmd
);

    localparam int unsigned BW    = id_width(NUM_OF_BANKS);
    localparam int unsigned RW    = id_width(NUM_OF_ROWS);
    localparam int unsigned CW    = id_width(NUM_OF_COLS);
    localparam int unsigned T_MAX = max2(max2(T_RCD, T_CL), max2(T_WR, T_RP));
    localparam int unsigned TW    = id_width(T_MAX + 1);

    // Timer holds the WAIT cycles still to run after the current one.
    localparam logic [TW-1:0] LD_RCD = (T_RCD > 0) ? TW'(T_RCD - 1) : '0;
    localparam logic [TW-1:0] LD_CL  = (T_CL  > 0) ? TW'(T_CL  - 1) : '0;
    localparam logic [TW-1:0] LD_WR  = (T_WR  > 0) ? TW'(T_WR  - 1) : '0;
    localparam logic [TW-1:0] LD_RP  = (T_RP  > 0) ? TW'(T_RP  - 1) : '0;

    state_e                r_state, w_state_next;
    cmd_e                  r_cmd;
    logic                  w_accept, w_tmr_load, w_tmr_dec, w_tmr_zero, w_capture;
    logic                  w_t_zero, w_err;
    logic [TW-1:0]         w_ld_val;
    logic [BW-1:0]         w_bank_enc;
    logic [RW-1:0]         w_row_enc;
    logic [CW-1:0]         w_col_enc;
    logic                  w_bank_bad, w_row_bad, w_col_bad;

    logic [NUM_OF_BANKS-1:0] r_open;
    logic [RW-1:0]           r_open_row [NUM_OF_BANKS];

    logic                  r_cmd_ack, r_bank_rw, r_buf_rw, r_rd_valid, r_proto_err;
    logic [BW-1:0]         r_bank_id;
    logic [RW-1:0]         r_row_id;
    logic [CW-1:0]         r_col_id;
    logic [DATA_WIDTH-1:0] r_dram_dout, r_rd_data;

    // Priority encoders: lowest set bit wins.
    always_comb begin
        w_bank_enc = '0;
        w_row_enc  = '0;
        w_col_enc  = '0;
        for (int i = int'(NUM_OF_BANKS) - 1; i >= 0; i--)
            if (io_cmd.bank_sel[i]) w_bank_enc = BW'(i);
        for (int i = int'(NUM_OF_ROWS) - 1; i >= 0; i--)
            if (io_cmd.row_sel[i]) w_row_enc = RW'(i);
        for (int i = int'(NUM_OF_COLS) - 1; i >= 0; i--)
            if (io_cmd.col_sel[i]) w_col_enc = CW'(i);
    end

    assign w_bank_bad = (io_cmd.bank_sel == '0) ||
                        ((io_cmd.bank_sel & (io_cmd.bank_sel - NUM_OF_BANKS'(1))) != '0);
    assign w_row_bad  = (io_cmd.row_sel == '0) ||
                        ((io_cmd.row_sel & (io_cmd.row_sel - NUM_OF_ROWS'(1))) != '0);
    assign w_col_bad  = (io_cmd.col_sel == '0) ||
                        ((io_cmd.col_sel & (io_cmd.col_sel - NUM_OF_COLS'(1))) != '0);

    // Protocol check against the bank table, evaluated on the accept edge.
    always_comb begin
        w_err = 1'b0;
        case (cmd_e'(io_cmd.cmd))
            CMD_ACT: w_err = w_bank_bad | w_row_bad | r_open[w_bank_enc];
            CMD_RD,
            CMD_WR:  w_err = w_bank_bad | w_row_bad | w_col_bad | !r_open[w_bank_enc] |
                             (r_open_row[w_bank_enc] != w_row_enc);
            CMD_PRE: w_err = w_bank_bad | !r_open[w_bank_enc];
            default: w_err = 1'b0;
        endcase
    end

    always_comb begin
        w_ld_val = LD_RCD;
        w_t_zero = (T_RCD == 0);
        case (r_cmd)
            CMD_ACT: begin w_ld_val = LD_RCD; w_t_zero = (T_RCD == 0); end
            CMD_RD:  begin w_ld_val = LD_CL;  w_t_zero = (T_CL  == 0); end
            CMD_WR:  begin w_ld_val = LD_WR;  w_t_zero = (T_WR  == 0); end
            CMD_PRE: begin w_ld_val = LD_RP;  w_t_zero = (T_RP  == 0); end
            default: begin w_ld_val = LD_RCD; w_t_zero = (T_RCD == 0); end
        endcase
    end

    dram_tmr #(.WIDTH(TW)) u_tmr (
        .clk        (clk),
        .rst_b      (rst_b),
        .i_load     (w_tmr_load),
        .i_load_val (w_ld_val),
        .i_dec      (w_tmr_dec),
        .o_zero_c   (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_dec    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: if (io_cmd.cmd_req) w_state_next = EXEC;
            EXEC: begin
                w_tmr_load = 1'b1;
                if (w_t_zero) begin
                    w_state_next = ACK;
                    w_capture    = (r_cmd == CMD_RD);
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (w_tmr_zero) begin
                    w_state_next = ACK;
                    w_capture    = (r_cmd == CMD_RD);
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ACK:     if (!io_cmd.cmd_req) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && io_cmd.cmd_req;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_cmd       <= CMD_ACT;
            r_cmd_ack   <= 1'b0;
            r_bank_id   <= '0;
            r_row_id    <= '0;
            r_col_id    <= '0;
            r_bank_rw   <= 1'b0;
            r_buf_rw    <= 1'b0;
            r_dram_dout <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_proto_err <= 1'b0;
            r_open      <= '0;
            for (int b = 0; b < int'(NUM_OF_BANKS); b++) r_open_row[b] <= '0;
        end else begin
            r_cmd_ack  <= (w_state_next == ACK);
            r_rd_valid <= w_capture;
            if (w_capture) r_rd_data <= io_cmd.dram_din;
            if ((r_state == ACK) && (w_state_next == IDLE)) r_dram_dout <= '0;
            if (w_accept) begin
                r_cmd     <= cmd_e'(io_cmd.cmd);
                r_bank_id <= w_bank_enc;
                r_row_id  <= w_row_enc;
                r_col_id  <= w_col_enc;
                if (w_err) r_proto_err <= 1'b1;
                case (cmd_e'(io_cmd.cmd))
                    CMD_ACT: begin
                        r_bank_rw              <= 1'b0;
                        r_open[w_bank_enc]     <= 1'b1;
                        r_open_row[w_bank_enc] <= w_row_enc;
                    end
                    CMD_RD:  r_buf_rw <= 1'b0;
                    CMD_WR: begin
                        r_buf_rw    <= 1'b1;
                        r_dram_dout <= io_cmd.wr_data;
                    end
                    CMD_PRE: begin
                        r_bank_rw          <= 1'b1;
                        r_open[w_bank_enc] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_cmd.cmd_ack   = r_cmd_ack;
    assign io_cmd.bank_id   = r_bank_id;
    assign io_cmd.row_id    = r_row_id;
    assign io_cmd.col_id    = r_col_id;
    assign io_cmd.bank_rw   = r_bank_rw;
    assign io_cmd.buf_rw    = r_buf_rw;
    assign io_cmd.dram_dout = r_dram_dout;
    assign io_cmd.rd_data   = r_rd_data;
    assign io_cmd.rd_valid  = r_rd_valid;
    assign io_cmd.proto_err = r_proto_err;

endmodule

// File: tb/tb_dram_cmd_timing.sv
// Directed vector bench for dram_cmd_timing with hand-computed expectations.
module tb_dram_cmd_timing;
    import dram_pkg::*;

    typedef struct {
        logic        rst;
        logic [1:0]  c;
        logic [7:0]  bsel;
        int          row;
        logic [7:0]  csel;
        logic [7:0]  wd;
        logic [7:0]  din;
        int          e_lat;
        logic [2:0]  e_bank;
        logic [6:0]  e_row;
        logic [2:0]  e_col;
        logic        e_err;
        logic        e_brw;
        logic        e_bufrw;
        logic [7:0]  e_dout;
        int          e_rv;
        logic [7:0]  e_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [13];

    always #5 clk = ~clk;

    dram_cmd_timing_if bus_if ();

    dram_cmd_timing dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .io_cmd (bus_if.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] row_onehot(input int r);
        logic [127:0] v;
        v = '0;
        if (r >= 0 && r < 128) v[r] = 1'b1;
        return v;
    endfunction

    task automatic drive(input logic [1:0] c, input logic [7:0] bsel, input int row,
                         input logic [7:0] csel, input logic [7:0] wd, input logic [7:0] din);
        bus_if.cmd      = c;
        bus_if.bank_sel = bsel;
        bus_if.row_sel  = row_onehot(row);
        bus_if.col_sel  = csel;
        bus_if.wr_data  = wd;
        bus_if.dram_din = din;
        bus_if.cmd_req  = 1'b1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        bus_if.cmd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",   32'(bus_if.cmd_ack),   32'd0);
        chk("rst_err",   32'(bus_if.proto_err), 32'd0);
        chk("rst_rv",    32'(bus_if.rd_valid),  32'd0);
        chk("rst_bank",  32'(bus_if.bank_id),   32'd0);
        chk("rst_dout",  32'(bus_if.dram_dout), 32'd0);
        rst_b = 1'b1;
    endtask

    task automatic wait_ack(inout int lat, inout int rv);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            lat++;
            rv += int'(bus_if.rd_valid);
            if (bus_if.cmd_ack) break;
        end
        chk("ack_rise", 32'(bus_if.cmd_ack), 32'd1);
    endtask

    task automatic release_req(inout int rv);
        bus_if.cmd_req = 1'b0;
        @(posedge clk);
        #1;
        rv += int'(bus_if.rd_valid);
        chk("ack_fall",  32'(bus_if.cmd_ack),   32'd0);
        chk("dout_idle", 32'(bus_if.dram_dout), 32'd0);
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] bsel, input int row,
                           input logic [7:0] csel, input logic [7:0] wd, input logic [7:0] din,
                           output int lat);
        int rv;
        lat = 0;
        rv  = 0;
        drive(c, bsel, row, csel, wd, din);
        wait_ack(lat, rv);
        release_req(rv);
    endtask

    initial begin
        int lat, rv;
        vecs[0]  = '{1'b1, CMD_ACT, 8'h04,   5, 8'h01, 8'h00, 8'h00, 5, 3'd2,   7'd5, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00};
        vecs[1]  = '{1'b0, CMD_WR,  8'h04,   5, 8'h08, 8'hA5, 8'h00, 4, 3'd2,   7'd5, 3'd3, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 8'h00};
        vecs[2]  = '{1'b0, CMD_RD,  8'h04,   5, 8'h08, 8'h00, 8'hA5, 4, 3'd2,   7'd5, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'hA5};
        vecs[3]  = '{1'b0, CMD_PRE, 8'h04,   5, 8'h01, 8'h00, 8'h00, 5, 3'd2,   7'd5, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00};
        vecs[4]  = '{1'b1, CMD_RD,  8'h40,   0, 8'h01, 8'h00, 8'h3C, 4, 3'd6,   7'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h3C};
        vecs[5]  = '{1'b0, CMD_PRE, 8'h04,   5, 8'h01, 8'h00, 8'h00, 5, 3'd2,   7'd5, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 8'h00};
        vecs[6]  = '{1'b0, CMD_RD,  8'h04,   5, 8'h08, 8'h00, 8'h77, 4, 3'd2,   7'd5, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1, 8'h77};
        vecs[7]  = '{1'b1, CMD_ACT, 8'h02,  10, 8'h01, 8'h00, 8'h00, 5, 3'd1,  7'd10, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00};
        vecs[8]  = '{1'b0, CMD_WR,  8'h02,  11, 8'h02, 8'h5A, 8'h00, 4, 3'd1,  7'd11, 3'd1, 1'b1, 1'b0, 1'b1, 8'h5A, 0, 8'h00};
        vecs[9]  = '{1'b0, CMD_ACT, 8'h02,  10, 8'h01, 8'h00, 8'h00, 5, 3'd1,  7'd10, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'h00};
        vecs[10] = '{1'b1, CMD_ACT, 8'h00,   7, 8'h01, 8'h00, 8'h00, 5, 3'd0,   7'd7, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h00};
        vecs[11] = '{1'b1, CMD_ACT, 8'h30,   2, 8'h01, 8'h00, 8'h00, 5, 3'd4,   7'd2, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h00};
        vecs[12] = '{1'b1, CMD_ACT, 8'h80, 127, 8'h80, 8'h00, 8'h00, 5, 3'd7, 7'd127, 3'd7, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00};

        bus_if.cmd_req  = 1'b0;
        bus_if.cmd      = '0;
        bus_if.bank_sel = '0;
        bus_if.row_sel  = '0;
        bus_if.col_sel  = '0;
        bus_if.wr_data  = '0;
        bus_if.dram_din = '0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].rst) do_reset();
            lat = 0;
            rv  = 0;
            drive(vecs[v].c, vecs[v].bsel, vecs[v].row, vecs[v].csel, vecs[v].wd, vecs[v].din);
            wait_ack(lat, rv);
            chk($sformatf("v%0d_lat", v),   32'(lat),                32'(vecs[v].e_lat));
            chk($sformatf("v%0d_bank", v),  32'(bus_if.bank_id),     32'(vecs[v].e_bank));
            chk($sformatf("v%0d_row", v),   32'(bus_if.row_id),      32'(vecs[v].e_row));
            chk($sformatf("v%0d_col", v),   32'(bus_if.col_id),      32'(vecs[v].e_col));
            chk($sformatf("v%0d_err", v),   32'(bus_if.proto_err),   32'(vecs[v].e_err));
            chk($sformatf("v%0d_brw", v),   32'(bus_if.bank_rw),     32'(vecs[v].e_brw));
            chk($sformatf("v%0d_bufrw", v), 32'(bus_if.buf_rw),      32'(vecs[v].e_bufrw));
            chk($sformatf("v%0d_dout", v),  32'(bus_if.dram_dout),   32'(vecs[v].e_dout));
            if (vecs[v].e_rv == 1)
                chk($sformatf("v%0d_rd", v), 32'(bus_if.rd_data),    32'(vecs[v].e_rd));
            release_req(rv);
            chk($sformatf("v%0d_rv_cnt", v), 32'(rv),                32'(vecs[v].e_rv));
        end

        // Reset in the middle of WAIT aborts and clears error and bank state.
        do_reset();
        run_cmd(CMD_ACT, 8'h08, 1, 8'h01, 8'h00, 8'h00, lat);
        chk("mid_pre_err0", 32'(bus_if.proto_err), 32'd0);
        run_cmd(CMD_RD, 8'h40, 1, 8'h01, 8'h00, 8'h11, lat);
        chk("mid_pre_err1", 32'(bus_if.proto_err), 32'd1);
        drive(CMD_ACT, 8'h08, 1, 8'h01, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_ack", 32'(bus_if.cmd_ack), 32'd0);
        do_reset();
        run_cmd(CMD_ACT, 8'h08, 1, 8'h01, 8'h00, 8'h00, lat);
        chk("mid_after_lat", 32'(lat), 32'd5);
        chk("mid_after_err", 32'(bus_if.proto_err), 32'd0);

        // Held request with select changes after the latch edge.
        do_reset();
        lat = 0;
        rv  = 0;
        drive(CMD_ACT, 8'h08, 4, 8'h01, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        lat = 2;
        bus_if.bank_sel = 8'h80;
        bus_if.row_sel  = row_onehot(9);
        wait_ack(lat, rv);
        chk("hold_lat", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            bus_if.bank_sel = 8'(1 << (i % 8));
            @(posedge clk);
            #1;
            chk($sformatf("hold_ack_%0d", i),  32'(bus_if.cmd_ack), 32'd1);
            chk($sformatf("hold_bank_%0d", i), 32'(bus_if.bank_id), 32'd3);
            chk($sformatf("hold_row_%0d", i),  32'(bus_if.row_id),  32'd4);
        end
        release_req(rv);
        chk("hold_err", 32'(bus_if.proto_err), 32'd0);
        run_cmd(CMD_PRE, 8'h08, 4, 8'h01, 8'h00, 8'h00, lat);
        chk("hold_pre_lat",  32'(lat),              32'd5);
        chk("hold_pre_err",  32'(bus_if.proto_err), 32'd0);
        chk("hold_pre_brw",  32'(bus_if.bank_rw),   32'd1);
        chk("hold_pre_bank", 32'(bus_if.bank_id),   32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
